// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file read path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    localparam int REG_DATA_W  = 32;
    localparam int REG_SEL_W   = 5;
    localparam int REG_NUM_REQ = 4;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    // OR-reduction rather than a priority scan: the input is one-hot by construction.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr.sv
// rr_arbiter: combinational one-hot grant over NUM_REQ requesters, plus the rotating priority pointer.
// Latency: grant is combinational from req_valid and ptr; pointer advances on the granting edge.
// Backpressure: none of its own; a requester without a grant simply waits. Build option: REGFILE_ARB_RR_EN.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
`ifdef REGFILE_ARB_RR_EN
    input  logic               clk,
`endif
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IDX_W = $clog2(NUM_REQ);

`ifdef REGFILE_ARB_RR_EN

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;

    // Search from ptr upward, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant_any  = 1'b1;
            end
        end
        // Nothing may be granted while reset is held.
        if (rst) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    // Next pointer: one past the winner, wrapping at NUM_REQ-1; hold when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`else

    // Fixed priority: lowest-index valid requester wins; higher indices can starve.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

`endif

endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares one register-file read mux among NUM_REQ requesters, one read per cycle.
// Latency: accept at edge E0 -> mux_sel after E0 -> rsp_valid/rsp_data after E0+1 (2 edges).
// Backpressure: req_ready is the one-hot grant; responses cannot be stalled. Build option: REGFILE_ARB_RR_EN.
module regfile_read_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = REG_NUM_REQ,
    parameter int DATA_W  = REG_DATA_W,
    parameter int SEL_W   = REG_SEL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*SEL_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [SEL_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]        mux_out,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]        rsp_data
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   grant_addr;

    // Stage 1: select driven to the mux, and who owns the read in flight.
    logic [SEL_W-1:0]   mux_sel_q,    mux_sel_d;
    logic [IDX_W-1:0]   s1_owner_q,   s1_owner_d;
    logic               s1_vld_q,     s1_vld_d;

    // Stage 2: captured read data and the owner's response strobe.
    logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,   rsp_data_d;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
`ifdef REGFILE_ARB_RR_EN
        .clk       (clk),
`endif
        .rst       (rst),
        .req_valid (req_valid),
        .grant     (grant)
    );

    // Winner index and its address; addresses of losing requesters are never looked at.
    always_comb begin
        grant_idx  = IDX_W'(onehot_to_idx(8'(grant)));
        grant_addr = req_addr[int'(grant_idx)*SEL_W +: SEL_W];
    end

    // Stage-1 next state: load select and owner on an accept, otherwise hold the select.
    always_comb begin
        mux_sel_d  = mux_sel_q;
        s1_owner_d = s1_owner_q;
        s1_vld_d   = 1'b0;
        if (|grant) begin
            mux_sel_d  = grant_addr;
            s1_owner_d = grant_idx;
            s1_vld_d   = 1'b1;
        end
    end

    // Stage-2 next state: capture the mux one cycle after the select, strobe only the owner.
    always_comb begin
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = '0;
        if (s1_vld_q) begin
            rsp_data_d  = mux_out;
            rsp_valid_d = NUM_REQ'(1) << s1_owner_q;
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_sel_q   <= '0;
            s1_owner_q  <= '0;
            s1_vld_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            mux_sel_q   <= mux_sel_d;
            s1_owner_q  <= s1_owner_d;
            s1_vld_q    <= s1_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = grant;
    assign mux_sel   = mux_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: directed request vectors, expected responses queued at accept.
// Latency: expects each response exactly two edges after its accept.
// Backpressure: none; responses are checked on the cycle they appear.
module tb_regfile_read_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*SW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [SW-1:0]   mux_sel;
    logic [DW-1:0]   mux_out;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;

    typedef struct {
        logic [N-1:0]  vld;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    regfile_read_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .SEL_W     (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file contents seen through the read mux.
    function automatic logic [DW-1:0] reg_val(input logic [SW-1:0] a);
        if (a == 5'd7) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 + {27'd0, a};
    endfunction

    assign mux_out = reg_val(mux_sel);

    function automatic logic [N*SW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, entered at posedge+1 and left at the next posedge+1.
    task automatic step(input logic [N-1:0] vld, input logic [N*SW-1:0] addrs,
                        input logic [N-1:0] exp_rdy, input string tag);
        logic [SW-1:0] a;
        a         = '0;
        req_valid = vld;
        req_addr  = addrs;
        #2;
        chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) a = addrs[i*SW +: SW];
        end
        if (exp_rdy != '0) sb.push_back('{exp_rdy, reg_val(a), cyc + 2});
        @(posedge clk);
        #1;
        if (exp_rdy != '0) chk({tag, "_sel"}, 32'(mux_sel), 32'(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, "idle");
    endtask

    // Monitor: pop and compare whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_rsp: got none expected vld=%b data=%h", sb[0].vld, sb[0].data);
                void'(sb.pop_front());
            end
            if (rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

`ifdef REGFILE_ARB_RR_EN
    localparam logic [N-1:0] ALL4_EXP [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [N-1:0] STARVE_ODD   = 4'b0100;
`else
    localparam logic [N-1:0] ALL4_EXP [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    localparam logic [N-1:0] STARVE_ODD   = 4'b0001;
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_addr  = pack(1, 2, 3, 4);

        // Reset state, with every requester asking.
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_sel", 32'(mux_sel), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four requesting continuously from reset (wraps 3 -> 0 in round-robin).
        for (int k = 0; k < 5; k++) step(4'b1111, pack(1, 2, 3, 4), ALL4_EXP[k], "all4");
        idle(3);

        // Idle: outputs hold the last read (register 1).
        for (int k = 0; k < 8; k++) begin
            step('0, pack(9, 9, 9, 9), '0, "hold");
            chk("hold_sel", 32'(mux_sel), 32'd1);
            chk("hold_data", rsp_data, reg_val(5'd1));
        end

        // Single read of register 7 by requester 1.
        step(4'b0010, pack(0, 7, 0, 0), 4'b0010, "single");
        idle(3);

        // Address 0 is an ordinary register.
        step(4'b0001, pack(0, 0, 0, 0), 4'b0001, "addr0");
        idle(3);

        // Back-to-back from requester 3, new address after each accept.
        for (int k = 0; k < 5; k++) step(4'b1000, pack(0, 0, 0, 10 + k), 4'b1000, "b2b");
        idle(3);

        // Requesters 0 and 2 both valid for 10 cycles.
        for (int k = 0; k < 10; k++)
            step(4'b0101, pack(5, 0, 9, 0), (k % 2 == 1) ? STARVE_ODD : 4'b0001, "pair");
        idle(3);

        // Reset between accept and capture: the in-flight read must vanish.
        step(4'b0010, pack(0, 7, 0, 0), 4'b0010, "preflight");
        req_valid = 4'b1111;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_sel", 32'(mux_sel), 32'h0);
        chk("mid_rst_data", rsp_data, 32'h0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        sb.delete();
        req_valid = '0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        idle(3);
        // Pointer restarted at 0: requester 0 wins with everyone asking.
        step(4'b1111, pack(1, 2, 3, 4), 4'b0001, "post_rst");
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
